// File: rtl/reg_f_ctx.sv
// reg_f_ctx: register file with two constant registers (R0 = 0, R1 = all ones),
// an accumulator at R2 and work registers above it. A small FSM saves or restores
// the non-constant registers to/from an internal context stack, one register per cycle.
module reg_f_ctx #(
    parameter  int WIDTH       = 8,
    parameter  int SIZE        = 11,
    parameter  int STACK_DEPTH = 4,
    localparam int AW          = $clog2(SIZE),
    localparam int DW          = $clog2(STACK_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    rf_addr_r1,
    output logic [WIDTH-1:0] rf_data_out1,
    input  logic [AW-1:0]    rf_addr_r2,
    output logic [WIDTH-1:0] rf_data_out2,
    input  logic [AW-1:0]    rf_addr_wr,
    input  logic             rf_data_we,
    input  logic [WIDTH-1:0] rf_data_in,
    input  logic             rf_ctx_push,
    input  logic             rf_ctx_pop,
    output logic             rf_ctx_busy,
    output logic [DW-1:0]    rf_ctx_depth,
    output logic             rf_ctx_full,
    output logic             rf_ctx_empty,
    output logic             rf_ctx_err,
    output logic             rf_acc_zero
);

    localparam int NSAVE  = SIZE - 2;
    localparam int KW     = (NSAVE > 1) ? $clog2(NSAVE) : 1;
    localparam int MWORDS = STACK_DEPTH * NSAVE;
    localparam int MAW    = (MWORDS > 1) ? $clog2(MWORDS) : 1;

    typedef enum logic [1:0] {IDLE, SAVE, RESTORE} state_t;

    state_t           state;
    logic [KW-1:0]    k;
    logic [DW-1:0]    depth;
    logic             err;
    logic [WIDTH-1:0] regs [2:SIZE-1];
    logic [WIDTH-1:0] mem  [0:MWORDS-1];
    logic [WIDTH-1:0] view [0:(2**AW)-1];
    logic [DW-1:0]    base;
    logic [MAW-1:0]   mem_addr;
    logic [WIDTH-1:0] save_data;
    logic [WIDTH-1:0] restore_data;
    logic             last;

    // Full address-space view: constants, live registers, and zero for unmapped addresses
    always_comb begin
        for (int i = 0; i < 2**AW; i++) begin
            view[i] = '0;
        end
        view[1] = '1;
        for (int i = 2; i < SIZE; i++) begin
            view[i] = regs[i];
        end
    end

    assign rf_data_out1 = view[rf_addr_r1];
    assign rf_data_out2 = view[rf_addr_r2];
    assign rf_acc_zero  = (regs[2] == '0);
    assign rf_ctx_busy  = (state != IDLE);
    assign rf_ctx_depth = depth;
    assign rf_ctx_full  = (depth == DW'(STACK_DEPTH));
    assign rf_ctx_empty = (depth == '0);
    assign rf_ctx_err   = err;
    assign last         = (k == KW'(NSAVE - 1));

    // Stack slot for the current step: saves go to the next free context, restores read the top one
    always_comb begin
        base = depth;
        if (state == RESTORE) begin
            base = depth - DW'(1);
        end
        mem_addr     = MAW'(int'(base) * NSAVE + int'(k));
        restore_data = mem[mem_addr];
        save_data    = '0;
        for (int i = 0; i < NSAVE; i++) begin
            if (k == KW'(i)) begin
                save_data = regs[i + 2];
            end
        end
    end

    // Stack storage is deliberately not reset; it is unreachable while depth is zero
    always_ff @(posedge clk) begin
        if (state == SAVE) begin
            mem[mem_addr] <= save_data;
        end
    end

    // Register writes, context FSM, depth tracking and the registered reject pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
            depth <= '0;
            err   <= 1'b0;
            for (int i = 2; i < SIZE; i++) begin
                regs[i] <= '0;
            end
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (rf_data_we) begin
                        for (int i = 2; i < SIZE; i++) begin
                            if (rf_addr_wr == AW'(i)) begin
                                regs[i] <= rf_data_in;
                            end
                        end
                    end
                    if (rf_ctx_push && rf_ctx_pop) begin
                        err <= 1'b1;
                    end else if (rf_ctx_push) begin
                        if (rf_ctx_full) begin
                            err <= 1'b1;
                        end else begin
                            state <= SAVE;
                            k     <= '0;
                        end
                    end else if (rf_ctx_pop) begin
                        if (rf_ctx_empty) begin
                            err <= 1'b1;
                        end else begin
                            state <= RESTORE;
                            k     <= '0;
                        end
                    end
                end
                SAVE: begin
                    if (rf_ctx_push || rf_ctx_pop) begin
                        err <= 1'b1;
                    end
                    if (last) begin
                        for (int i = 2; i < SIZE; i++) begin
                            regs[i] <= '0;
                        end
                        depth <= depth + DW'(1);
                        state <= IDLE;
                        k     <= '0;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                RESTORE: begin
                    if (rf_ctx_push || rf_ctx_pop) begin
                        err <= 1'b1;
                    end
                    for (int i = 0; i < NSAVE; i++) begin
                        if (k == KW'(i)) begin
                            regs[i + 2] <= restore_data;
                        end
                    end
                    if (last) begin
                        depth <= depth - DW'(1);
                        state <= IDLE;
                        k     <= '0;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    k     <= '0;
                end
            endcase
        end
    end

endmodule
